ppu_out_packer: RTL

- Sink for the post-processing unit output streams (add/remap/conv style: data, vld, last).
- Packs two consecutive IN_WIDTH PPU result beats into one OUT_WIDTH AXI-Stream beat and buffers the packed words in a FIFO.
- Drives a DDR-side AXIS master with full tready backpressure.
- The PPU pipeline cannot stall, so the block raises an almost-full throttle to the upstream scheduler and flags any overflow.

---
 rtl/ppu_out_packer_if.sv | 32 +++
 rtl/ppu_out_packer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ppu_out_packer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ppu_res_if / axis_if : PPU result stream and AXI-Stream bundles          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

interface ppu_res_if #(
  parameter int IN_WIDTH = 256
);
  logic [IN_WIDTH-1:0] in_data;
  logic                in_vld;
  logic                in_last;
  logic                in_afull;

  modport master (output in_data, in_vld, in_last, input in_afull);
  modport slave  (input in_data, in_vld, in_last, output in_afull);
endinterface

interface axis_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/ppu_out_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ppu_out_packer : pairs PPU result beats into AXIS words through a FIFO   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module ppu_out_packer #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 512,
  parameter int DEPTH     = 32,
  parameter int AF_MARGIN = 6
) (
  input  wire logic        clk,
  input  wire logic        rst,
  ppu_res_if.slave         ppu,
  axis_if.master           m_axis,
  output logic             ovf,
  output logic [31:0]      out_beats
);

  localparam int KEEP_W   = OUT_WIDTH / 8;
  localparam int IN_KEEP  = IN_WIDTH / 8;
  localparam int ENTRY_W  = OUT_WIDTH + KEEP_W + 1;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int AF_LEVEL = DEPTH - AF_MARGIN;

  typedef enum logic [0:0] {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   half_q, half_d;

  logic                  push;
  logic [OUT_WIDTH-1:0]  push_data;
  logic [KEEP_W-1:0]     push_keep;
  logic                  push_last;

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic [OUT_WIDTH-1:0]  out_data_q;
  logic [KEEP_W-1:0]     out_keep_q;
  logic                  out_last_q;
  logic                  out_vld_q;

  logic                  afull_q;
  logic                  ovf_q;
  logic [31:0]           beats_q;

  logic                  fifo_empty, fifo_full;
  logic                  out_free, handshake;
  logic                  pop, bypass, wr_en, drop;
  logic [ENTRY_W-1:0]    push_entry, head_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOW;
      half_q  <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
    end
  end

  // Packer: the first beat of a pair parks in half_q; a lone last beat goes out half-filled.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    push      = 1'b0;
    push_data = '0;
    push_keep = '0;
    push_last = 1'b0;
    if (ppu.in_vld) begin
      unique case (state_q)
        ST_LOW: begin
          if (ppu.in_last) begin
            push      = 1'b1;
            push_data = {{IN_WIDTH{1'b0}}, ppu.in_data};
            push_keep = {{IN_KEEP{1'b0}}, {IN_KEEP{1'b1}}};
            push_last = 1'b1;
          end else begin
            half_d  = ppu.in_data;
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          push      = 1'b1;
          push_data = {ppu.in_data, half_q};
          push_keep = '1;
          push_last = ppu.in_last;
          state_d   = ST_LOW;
        end
        default: state_d = ST_LOW;
      endcase
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign handshake  = out_vld_q & m_axis.tready;
  assign out_free   = ~out_vld_q | m_axis.tready;
  assign pop        = out_free & ~fifo_empty;
  // An empty FIFO lets a fresh word go straight to the output register.
  assign bypass     = out_free & fifo_empty & push;
  assign wr_en      = push & ~bypass & (~fifo_full | pop);
  assign drop       = push & fifo_full & ~pop;

  assign push_entry = {push_data, push_keep, push_last};
  assign head_entry = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else if (pop) begin
      {out_data_q, out_keep_q, out_last_q} <= head_entry;
      out_vld_q                            <= 1'b1;
    end else if (bypass) begin
      {out_data_q, out_keep_q, out_last_q} <= push_entry;
      out_vld_q                            <= 1'b1;
    end else if (handshake) begin
      out_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      beats_q <= '0;
    end else begin
      afull_q <= (count_q >= CNT_W'(AF_LEVEL));
      ovf_q   <= ovf_q | drop;
      if (handshake) begin
        beats_q <= beats_q + 32'd1;
      end
    end
  end

  assign ppu.in_afull  = afull_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tkeep  = out_keep_q;
  assign m_axis.tlast  = out_last_q;
  assign m_axis.tvalid = out_vld_q;
  assign ovf           = ovf_q;
  assign out_beats     = beats_q;

endmodule

`default_nettype wire
